jtag_sequencer: RTL and testbench

- Upstream driver for the on-chip JTAG test access port. Converts host-level commands (TAP reset, IR shift, DR shift, idle cycles) into cycle-exact TMS/TDI streams.
- Captures the TDO bits returned by the TAP into a response word.
- Lives in the same TCK domain as the TAP and shares its TRST.
- Lets fabric-side logic or a bench exercise IDCODE/USERCODE/EXTEST/BYPASS without an external probe.

---
 rtl/jtag_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_jtag_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_sequencer.sv
// JTAG sequencer: turns TAP-reset / IR / DR / idle commands into TMS/TDI streams and captures TDO.
// Optional JTAG_SEQ_STATE_OUT_EN adds TAP_STATE, a mirror of the TAP controller state (IEEE 1149.1 encoding).
module jtag_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 6
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_TYPE,
    input  logic [LEN_W-1:0]  CMD_LEN,
    input  logic [DATA_W-1:0] CMD_DATA,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic              BUSY
`ifdef JTAG_SEQ_STATE_OUT_EN
    ,
    output logic [3:0]        TAP_STATE
`endif
);

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_IDLE  = 2'd3;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    typedef enum logic [3:0] {
        TLR, IDLE, RST_SEQ, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, DONE
    } state_e;

    state_e             state_q, state_n;
    logic [LEN_W-1:0]   cnt_q, cnt_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic               is_ir_q, is_ir_n;
    logic [DATA_W-1:0]  data_q, data_n;
    logic [DATA_W-1:0]  mask_q, mask_n;
    logic               tms_n, tdi_n, rsp_valid_n, rsp_err_n, capture;
    logic [DATA_W-1:0]  rsp_data_n;
    logic [LEN_W:0]     cnt_inc;
    logic [LEN_W-1:0]   len_clamped;

    assign cnt_inc     = (LEN_W+1)'(cnt_q) + (LEN_W+1)'(1);
    assign len_clamped = (CMD_LEN > MAX_LEN) ? MAX_LEN : CMD_LEN;

    // Next state plus the TMS/TDI values presented after the coming edge
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        len_n       = len_q;
        is_ir_n     = is_ir_q;
        data_n      = data_q;
        mask_n      = mask_q;
        tms_n       = 1'b0;
        tdi_n       = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_data_n  = RSP_DATA;
        capture     = 1'b0;
        case (state_q)
            TLR: begin
                if (cnt_q == '0) begin
                    cnt_n = LEN_W'(1);
                end else begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    cnt_n      = '0;
                    is_ir_n    = (CMD_TYPE == CMD_IR);
                    len_n      = CMD_LEN;
                    data_n     = CMD_DATA;
                    mask_n     = DATA_W'(1);
                    rsp_data_n = '0;
                    case (CMD_TYPE)
                        CMD_RESET: begin
                            state_n = RST_SEQ;
                            tms_n   = 1'b1;
                        end
                        CMD_IDLE: state_n = RUN;
                        default: begin
                            // Zero-length shift is rejected without touching the TAP
                            if (CMD_LEN == '0) begin
                                rsp_valid_n = 1'b1;
                                rsp_err_n   = 1'b1;
                            end else begin
                                len_n   = len_clamped;
                                state_n = SEL_DR;
                                tms_n   = 1'b1;
                            end
                        end
                    endcase
                end
            end
            RST_SEQ: begin
                if (cnt_q == LEN_W'(5)) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + LEN_W'(1);
                    tms_n = (cnt_q < LEN_W'(4));
                end
            end
            RUN: begin
                if (cnt_inc >= (LEN_W+1)'(len_q)) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + LEN_W'(1);
                end
            end
            SEL_DR: begin
                if (is_ir_q) begin
                    state_n = SEL_IR;
                    tms_n   = 1'b1;
                end else begin
                    state_n = CAPTURE;
                end
            end
            SEL_IR:  state_n = CAPTURE;
            CAPTURE: begin
                state_n = SHIFT;
                cnt_n   = '0;
            end
            SHIFT: begin
                // TDO for bit k arrives one edge after TDI bit k is presented
                capture = (cnt_q != '0);
                tdi_n   = data_q[0];
                data_n  = data_q >> 1;
                cnt_n   = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) begin
                    tms_n   = 1'b1;
                    state_n = EXIT1;
                end
            end
            EXIT1: begin
                capture = 1'b1;
                tms_n   = 1'b1;
                state_n = UPDATE;
            end
            UPDATE: state_n = DONE;
            DONE: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
            end
            default: state_n = TLR;
        endcase
        if (capture) begin
            rsp_data_n = RSP_DATA | (TDO ? mask_q : '0);
            mask_n     = mask_q << 1;
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q   <= TLR;
            cnt_q     <= '0;
            len_q     <= '0;
            is_ir_q   <= 1'b0;
            data_q    <= '0;
            mask_q    <= '0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_DATA  <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            len_q     <= len_n;
            is_ir_q   <= is_ir_n;
            data_q    <= data_n;
            mask_q    <= mask_n;
            TMS       <= tms_n;
            TDI       <= tdi_n;
            CMD_READY <= (state_n == IDLE);
            BUSY      <= (state_n != IDLE);
            RSP_VALID <= rsp_valid_n;
            RSP_ERR   <= rsp_err_n;
            RSP_DATA  <= rsp_data_n;
        end
    end

`ifdef JTAG_SEQ_STATE_OUT_EN
    logic [3:0] tap_n;

    // Standard TAP controller transition, driven by the TMS the TAP is sampling
    always_comb begin
        tap_n = TAP_STATE;
        case (TAP_STATE)
            4'hF: tap_n = TMS ? 4'hF : 4'hC;
            4'hC: tap_n = TMS ? 4'h7 : 4'hC;
            4'h7: tap_n = TMS ? 4'h4 : 4'h6;
            4'h6: tap_n = TMS ? 4'h1 : 4'h2;
            4'h2: tap_n = TMS ? 4'h1 : 4'h2;
            4'h1: tap_n = TMS ? 4'h5 : 4'h3;
            4'h3: tap_n = TMS ? 4'h0 : 4'h3;
            4'h0: tap_n = TMS ? 4'h5 : 4'h2;
            4'h5: tap_n = TMS ? 4'h7 : 4'hC;
            4'h4: tap_n = TMS ? 4'hF : 4'hE;
            4'hE: tap_n = TMS ? 4'h9 : 4'hA;
            4'hA: tap_n = TMS ? 4'h9 : 4'hA;
            4'h9: tap_n = TMS ? 4'hD : 4'hB;
            4'hB: tap_n = TMS ? 4'h8 : 4'hB;
            4'h8: tap_n = TMS ? 4'hD : 4'hA;
            4'hD: tap_n = TMS ? 4'h7 : 4'hC;
            default: tap_n = 4'hF;
        endcase
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) TAP_STATE <= 4'hF;
        else       TAP_STATE <= tap_n;
    end
`endif

endmodule

// File: tb/tb_jtag_sequencer.sv
// Bench for jtag_sequencer: drives commands into a behavioural TAP (IDCODE/BYPASS) and scores responses.
module tb_jtag_sequencer;

    localparam logic [1:0] T_RST = 2'd0, T_IR = 2'd1, T_DR = 2'd2, T_IDLE = 2'd3;
    localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SDR = 4'h7, S_CDR = 4'h6, S_SHDR = 4'h2,
                           S_E1DR = 4'h1, S_PDR = 4'h3, S_E2DR = 4'h0, S_UDR = 4'h5, S_SIR = 4'h4,
                           S_CIR = 4'hE, S_SHIR = 4'hA, S_E1IR = 4'h9, S_PIR = 4'hB, S_E2IR = 4'h8,
                           S_UIR = 4'hD;
    localparam logic [3:0]  OP_IDCODE = 4'h7;
    localparam logic [31:0] ID_VALUE  = 32'h1234_5678;

    logic        TCK = 1'b0;
    logic        TRST = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE = '0;
    logic [5:0]  CMD_LEN = '0;
    logic [31:0] CMD_DATA = '0;
    logic        TMS, TDI, TDO;
    logic        RSP_VALID, RSP_ERR, BUSY;
    logic [31:0] RSP_DATA;
`ifdef JTAG_SEQ_STATE_OUT_EN
    logic [3:0]  TAP_STATE;
`endif

    jtag_sequencer #(.DATA_W(32), .LEN_W(6)) dut (
        .TCK(TCK), .TRST(TRST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_LEN(CMD_LEN), .CMD_DATA(CMD_DATA),
        .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
`ifdef JTAG_SEQ_STATE_OUT_EN
        , .TAP_STATE(TAP_STATE)
`endif
    );

    always #5 TCK = ~TCK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural TAP: 4-bit IR, IDCODE register, BYPASS for every other opcode
    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            S_TLR:  return m ? S_TLR  : S_RTI;
            S_RTI:  return m ? S_SDR  : S_RTI;
            S_SDR:  return m ? S_SIR  : S_CDR;
            S_CDR:  return m ? S_E1DR : S_SHDR;
            S_SHDR: return m ? S_E1DR : S_SHDR;
            S_E1DR: return m ? S_UDR  : S_PDR;
            S_PDR:  return m ? S_E2DR : S_PDR;
            S_E2DR: return m ? S_UDR  : S_SHDR;
            S_UDR:  return m ? S_SDR  : S_RTI;
            S_SIR:  return m ? S_TLR  : S_CIR;
            S_CIR:  return m ? S_E1IR : S_SHIR;
            S_SHIR: return m ? S_E1IR : S_SHIR;
            S_E1IR: return m ? S_UIR  : S_PIR;
            S_PIR:  return m ? S_E2IR : S_PIR;
            S_E2IR: return m ? S_UIR  : S_SHIR;
            default: return m ? S_SDR : S_RTI;
        endcase
    endfunction

    logic [3:0]  tap_st;
    logic [3:0]  ir, ir_sr;
    logic [31:0] dr_sr;

    always @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            tap_st <= S_TLR;
            ir     <= OP_IDCODE;
            ir_sr  <= '0;
            dr_sr  <= '0;
        end else begin
            case (tap_st)
                S_TLR:  ir    <= OP_IDCODE;
                S_CIR:  ir_sr <= 4'b0001;
                S_SHIR: ir_sr <= {TDI, ir_sr[3:1]};
                S_UIR:  ir    <= ir_sr;
                S_CDR:  dr_sr <= (ir == OP_IDCODE) ? ID_VALUE : 32'h0;
                S_SHDR: dr_sr <= (ir == OP_IDCODE) ? {TDI, dr_sr[31:1]} : {31'h0, TDI};
                default: ;
            endcase
            tap_st <= tap_next(tap_st, TMS);
        end
    end

    assign TDO = (tap_st == S_SHIR) ? ir_sr[0] : (tap_st == S_SHDR) ? dr_sr[0] : 1'b0;

    typedef struct {
        logic [31:0] rsp;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    // Scoreboard: every response pulse must match the oldest outstanding expectation
    always @(negedge TCK) begin
        if (TRST && RSP_VALID) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_unexpected: got RSP_VALID with data 0x%0h, expected none", RSP_DATA);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", RSP_DATA, e.rsp);
                chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
                chk("ready_with_valid", 32'(CMD_READY), 32'd1);
                chk("busy_with_valid", 32'(BUSY), 32'd0);
            end
        end
`ifdef JTAG_SEQ_STATE_OUT_EN
        if (TRST) chk("tap_state", 32'(TAP_STATE), 32'(tap_st));
`endif
    end

    logic tms_log [256];
    logic tdi_log [256];

    task automatic run_cmd(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                           input logic [31:0] er, input logic ee, input int exp_edges);
        int edges;
        int waitc;
        rsp_t e;
        @(negedge TCK);
        CMD_VALID = 1'b1;
        CMD_TYPE  = t;
        CMD_LEN   = l;
        CMD_DATA  = d;
        waitc = 0;
        while (!CMD_READY && waitc < 200) begin
            @(negedge TCK);
            waitc++;
        end
        if (!CMD_READY) begin
            chk("accept_timeout", 32'(CMD_READY), 32'd1);
            CMD_VALID = 1'b0;
            return;
        end
        e.rsp = er;
        e.err = ee;
        exp_q.push_back(e);
        @(posedge TCK);
        #1;
        CMD_VALID = 1'b0;
        CMD_DATA  = ~d;
        CMD_LEN   = 6'($urandom_range(0, 63));
        edges = 0;
        @(negedge TCK);
        tms_log[0] = TMS;
        tdi_log[0] = TDI;
        while (!RSP_VALID && edges < 200) begin
            @(posedge TCK);
            edges++;
            @(negedge TCK);
            tms_log[edges] = TMS;
            tdi_log[edges] = TDI;
        end
        chk("edge_count", 32'(edges), 32'(exp_edges));
        if (exp_edges == 0) chk("tms_err_idle", 32'(tms_log[0]), 32'd0);
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [5:0]  l;
        logic [31:0] d;
        logic [31:0] rsp;
        logic        err;
        int          edges;
    } vec_t;
    vec_t vecs [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] got_tms, got_tdi, exp_tms, exp_tdi;
        logic [6:0] rv, exp_rv;
        int waitc;
        rsp_t e;

        vecs[0]  = '{T_DR,   6'd32, 32'h0000_0000, 32'h1234_5678, 1'b0, 37};
        vecs[1]  = '{T_DR,   6'd16, 32'h0000_FFFF, 32'h0000_5678, 1'b0, 21};
        vecs[2]  = '{T_IDLE, 6'd0,  32'h0,         32'h0,         1'b0, 1};
        vecs[3]  = '{T_IDLE, 6'd5,  32'h0,         32'h0,         1'b0, 5};
        vecs[4]  = '{T_RST,  6'd0,  32'hDEAD_BEEF, 32'h0,         1'b0, 6};
        vecs[5]  = '{T_IR,   6'd0,  32'h0000_0007, 32'h0,         1'b1, 0};
        vecs[6]  = '{T_DR,   6'd0,  32'h0000_0001, 32'h0,         1'b1, 0};
        vecs[7]  = '{T_IR,   6'd4,  32'h0000_000F, 32'h0000_0001, 1'b0, 10};
        vecs[8]  = '{T_DR,   6'd1,  32'h0000_0001, 32'h0000_0000, 1'b0, 6};
        vecs[9]  = '{T_DR,   6'd8,  32'h0000_00A5, 32'h0000_004A, 1'b0, 13};
        vecs[10] = '{T_DR,   6'd63, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 37};
        vecs[11] = '{T_IR,   6'd4,  32'h0000_0007, 32'h0000_0001, 1'b0, 10};
        vecs[12] = '{T_DR,   6'd40, 32'h0000_0000, 32'h1234_5678, 1'b0, 37};

        // Reset state and exit sequence
        repeat (3) @(negedge TCK);
        chk("rst_tms", 32'(TMS), 32'd1);
        chk("rst_tdi", 32'(TDI), 32'd0);
        chk("rst_ready", 32'(CMD_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd1);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
        chk("rst_rsp_data", RSP_DATA, 32'd0);
        TRST = 1'b1;
        @(negedge TCK);
        chk("exit1_tms", 32'(TMS), 32'd0);
        chk("exit1_ready", 32'(CMD_READY), 32'd0);
        @(negedge TCK);
        chk("exit2_ready", 32'(CMD_READY), 32'd1);
        chk("exit2_busy", 32'(BUSY), 32'd0);

        // IR shift selecting IDCODE, with full TMS/TDI stream check
        run_cmd(T_IR, 6'd4, 32'h7, 32'h1, 1'b0, 10);
        for (int k = 0; k < 10; k++) begin
            got_tms[k] = tms_log[k];
            got_tdi[k] = tdi_log[k];
        end
        exp_tms = 10'b0110000011;
        exp_tdi = 10'b0001110000;
        chk("ir_tms_stream", 32'(got_tms), 32'(exp_tms));
        chk("ir_tdi_stream", 32'(got_tdi), 32'(exp_tdi));
        chk("tap_ir_idcode", 32'(ir), 32'(OP_IDCODE));

        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].t, vecs[i].l, vecs[i].d, vecs[i].rsp, vecs[i].err, vecs[i].edges);
        end

        // Back-to-back: a held CMD_VALID is taken the edge after RSP_VALID
        @(negedge TCK);
        CMD_VALID = 1'b1;
        CMD_TYPE  = T_IDLE;
        CMD_LEN   = 6'd2;
        CMD_DATA  = '0;
        waitc = 0;
        while (!CMD_READY && waitc < 200) begin
            @(negedge TCK);
            waitc++;
        end
        e.rsp = '0;
        e.err = 1'b0;
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(posedge TCK);
        rv = '0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge TCK);
            if (k == 3) begin
                #1;
                CMD_VALID = 1'b0;
            end
            @(negedge TCK);
            rv[k] = RSP_VALID;
        end
        exp_rv = 7'b0100100;
        chk("b2b_valid_pattern", 32'(rv), 32'(exp_rv));

        // Reset in the middle of a DR shift (after bit 10 is captured)
        @(negedge TCK);
        CMD_VALID = 1'b1;
        CMD_TYPE  = T_DR;
        CMD_LEN   = 6'd32;
        CMD_DATA  = '0;
        waitc = 0;
        while (!CMD_READY && waitc < 200) begin
            @(negedge TCK);
            waitc++;
        end
        @(posedge TCK);
        #1;
        CMD_VALID = 1'b0;
        repeat (14) @(posedge TCK);
        @(negedge TCK);
        chk("pre_abort_busy", 32'(BUSY), 32'd1);
        TRST = 1'b0;
        #1;
        chk("abort_tms", 32'(TMS), 32'd1);
        chk("abort_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("abort_rsp_data", RSP_DATA, 32'd0);
        repeat (2) @(negedge TCK);
        chk("abort_ready", 32'(CMD_READY), 32'd0);
        TRST = 1'b1;
        repeat (2) @(negedge TCK);
        chk("abort_exit_ready", 32'(CMD_READY), 32'd1);
        run_cmd(T_RST, 6'd0, 32'h0, 32'h0, 1'b0, 6);
        run_cmd(T_IR, 6'd4, 32'h7, 32'h1, 1'b0, 10);
        run_cmd(T_DR, 6'd32, 32'h0, ID_VALUE, 1'b0, 37);

        repeat (4) @(negedge TCK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
